// File: rtl/pending_request_scheduler_12.sv
// Fixed-priority scheduler: latches 12 request lines as pending and grants the
// shared resource to the highest unmasked candidate until done or timeout.
module pending_request_scheduler_12 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] req,
    input  logic [11:0] mask,
    input  logic        done,
    output logic        grant_valid,
    output logic [3:0]  grant_code,
    output logic [11:0] grant_onehot,
    output logic        timeout,
    output logic [11:0] pending
);

    localparam int unsigned N      = 12;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [N-1:0]       cand;
    logic [CODE_W-1:0]  win_idx;
    logic [N-1:0]       win_oh;

    // Highest set candidate bit wins; later iterations override earlier ones.
    always_comb begin
        cand    = (pending | req) & ~mask;
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                win_idx = CODE_W'(i);
            end
        end
        win_oh = N'(1) << win_idx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            pending      <= '0;
            grant_valid  <= 1'b0;
            grant_code   <= '0;
            grant_onehot <= '0;
            timeout      <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (cand != '0) begin
                        // Winner's request is consumed by the grant, not left pending.
                        state        <= GRANT;
                        cnt          <= '0;
                        grant_valid  <= 1'b1;
                        grant_code   <= win_idx + CODE_W'(1);
                        grant_onehot <= win_oh;
                        pending      <= (pending | req) & ~win_oh;
                    end else begin
                        pending <= pending | req;
                    end
                end
                GRANT: begin
                    pending <= pending | req;
                    if (done || (cnt == CNT_LAST)) begin
                        state        <= RELEASE;
                        grant_valid  <= 1'b0;
                        grant_code   <= '0;
                        grant_onehot <= '0;
                        timeout      <= ~done;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    pending <= pending | req;
                    state   <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    grant_valid  <= 1'b0;
                    grant_code   <= '0;
                    grant_onehot <= '0;
                end
            endcase
        end
    end

endmodule
